// File: rtl/sink_lookup.sv
// rtl/sink_lookup.sv - scans the sink table in memory for this node's ID and writes back the match result
module sink_lookup #(
    parameter  int DATA_W      = 16,
    parameter  int ADDR_W      = 11,
    parameter  int ID_ADDR     = 2,
    parameter  int SINK_BASE   = 16,
    parameter  int MAX_SINKS   = 8,
    parameter  int RESULT_ADDR = 3,
    localparam int IDX_W       = (MAX_SINKS > 1) ? $clog2(MAX_SINKS) : 1
) (
    input  logic              clock,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    output logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              forAggregation,
    output logic [IDX_W-1:0]  sink_idx,
    output logic              done
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] A_ID    = ADDR_W'(ID_ADDR);
    localparam logic [ADDR_W-1:0] A_CNT   = ADDR_W'(SINK_BASE);
    localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(SINK_BASE + 1);
    localparam logic [ADDR_W-1:0] A_SCAN0 = ADDR_W'(SINK_BASE + 2);
    localparam logic [ADDR_W-1:0] A_RES   = ADDR_W'(RESULT_ADDR);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_SINKS);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_CNT, LD_CNT, SCAN, WRITE, FINISH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              wr_en_q, wr_en_d, done_q, done_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              for_agg_q, for_agg_d;
    logic [IDX_W-1:0]  sink_idx_q, sink_idx_d;
    logic [DATA_W-1:0] node_id_q, node_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  k_q, k_d, idx_q, idx_d;
    logic              match_q, match_d;
    logic              stalled_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rdata;

    // While stalled the memory keeps answering the already-advanced address,
    // so the word that belonged to the frozen state is parked in hold_q.
    assign rdata = stalled_q ? hold_q : data_in;

    always_comb begin
        state_d    = state_q;
        node_id_d  = node_id_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        idx_d      = idx_q;
        match_d    = match_q;
        for_agg_d  = for_agg_q;
        sink_idx_d = sink_idx_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE:    if (start) state_d = RD_ID;
            RD_ID:   state_d = RD_CNT;
            RD_CNT: begin
                node_id_d = rdata;
                state_d   = LD_CNT;
            end
            LD_CNT: begin
                cnt_d   = (rdata > DATA_W'(MAX_SINKS)) ? CNT_MAX : CNT_W'(rdata);
                k_d     = '0;
                idx_d   = '0;
                match_d = 1'b0;
                state_d = (rdata == '0) ? WRITE : SCAN;
            end
            SCAN: begin
                if (rdata == node_id_q) begin
                    match_d = 1'b1;
                    idx_d   = k_q;
                    state_d = WRITE;
                end else if ({1'b0, k_q} == cnt_q - CNT_W'(1)) begin
                    state_d = WRITE;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            WRITE:   state_d = FINISH;
            FINISH: begin
                for_agg_d  = match_q;
                sink_idx_d = match_q ? idx_q : '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == WRITE && state_q != WRITE)
            data_out_d = DATA_W'({idx_d, match_d});
    end

    // Registered outputs are computed from the state being entered.
    always_comb begin
        address_d = '0;
        case (state_d)
            RD_ID:   address_d = A_ID;
            RD_CNT:  address_d = A_CNT;
            LD_CNT:  address_d = A_FIRST;
            SCAN:    address_d = A_SCAN0 + ADDR_W'(k_d);
            WRITE:   address_d = A_RES;
            default: address_d = '0;
        endcase
        wr_en_d = (state_d == WRITE);
        done_d  = (state_d == FINISH);
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            address_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            for_agg_q  <= 1'b0;
            sink_idx_q <= '0;
            node_id_q  <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            idx_q      <= '0;
            match_q    <= 1'b0;
            stalled_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            stalled_q <= ~en;
            if (!en && !stalled_q) hold_q <= data_in;
            if (en) begin
                state_q    <= state_d;
                address_q  <= address_d;
                wr_en_q    <= wr_en_d;
                done_q     <= done_d;
                data_out_q <= data_out_d;
                for_agg_q  <= for_agg_d;
                sink_idx_q <= sink_idx_d;
                node_id_q  <= node_id_d;
                cnt_q      <= cnt_d;
                k_q        <= k_d;
                idx_q      <= idx_d;
                match_q    <= match_d;
            end
        end
    end

    // Strobes are masked by en so a frozen WRITE/FINISH neither writes nor signals.
    assign address        = address_q;
    assign wr_en          = wr_en_q & en;
    assign done           = done_q & en;
    assign data_out       = data_out_q;
    assign forAggregation = for_agg_q;
    assign sink_idx       = sink_idx_q;

endmodule

// File: doc/sink_lookup.md
SINK_LOOKUP -- requirements
Module: sink_lookup

Parameters
REQ-001 SHALL have parameter DATA_W, default 16, meaning the memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11, meaning the memory address width in bits.
REQ-003 SHALL have parameter ID_ADDR, default 2, meaning the address of this node's ID word.
REQ-004 SHALL have parameter SINK_BASE, default 16, meaning the address of the sink count word; sink entries follow at SINK_BASE+1 onward.
REQ-005 SHALL have parameter MAX_SINKS, default 8 (minimum 1), meaning the maximum number of sink entries scanned.
REQ-006 SHALL have parameter RESULT_ADDR, default 3, meaning the address the result word is written to.
REQ-007 SHALL define IDX_W as clog2(MAX_SINKS), with a minimum of 1.

Interface
REQ-008 clock  in  1  sole clock; all state changes on its rising edge.
REQ-009 nrst  in  1  reset; asynchronous, active-low.
REQ-010 en  in  1  enable; low freezes the block (see REQ-021).
REQ-011 start  in  1  request a lookup; sampled only in IDLE.
REQ-012 address  out  ADDR_W  memory address, registered.
REQ-013 wr_en  out  1  memory write strobe, registered.
REQ-014 data_in  in  DATA_W  memory read data; the word for the address presented in cycle N is valid in cycle N+1.
REQ-015 data_out  out  DATA_W  memory write data, registered.
REQ-016 forAggregation  out  1  result flag: this node ID matches a sink entry.
REQ-017 sink_idx  out  IDX_W  index of the matching entry; 0 when there is no match.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have the states IDLE, RD_ID, RD_CNT, LD_CNT, SCAN, WRITE and FINISH; each output value listed below is the value during the cycle the FSM is in that state.
REQ-020 IDLE: address=0, wr_en=0, done=0; start=1 and en=1 -> RD_ID; otherwise remain in IDLE.
REQ-021 With en=0, the FSM, counters, captured values and address SHALL hold, wr_en SHALL be 0 and done SHALL be 0; operation resumes from the held state when en returns to 1.
REQ-022 RD_ID: address=ID_ADDR; -> RD_CNT.
REQ-023 RD_CNT: address=SINK_BASE; node_id <= data_in; -> LD_CNT.
REQ-024 LD_CNT: address=SINK_BASE+1; cnt <= min(data_in, MAX_SINKS); k <= 0; data_in==0 -> WRITE with match=0; otherwise -> SCAN.
REQ-025 SCAN (data_in = entry k): address=SINK_BASE+2+k.
  - data_in==node_id -> match=1, idx=k, -> WRITE (first match wins, early exit).
  - else k==cnt-1 -> match=0, -> WRITE.
  - else k <= k+1, remain in SCAN.
REQ-026 All address arithmetic SHALL be modulo 2^ADDR_W, wrapping silently.
REQ-027 WRITE: address=RESULT_ADDR, wr_en=1, data_out = {zero-pad, idx[IDX_W-1:0], match}; -> FINISH.
REQ-028 FINISH: done=1, wr_en=0; forAggregation<=match and sink_idx<=(match ? idx : 0); -> IDLE.
REQ-029 forAggregation and sink_idx SHALL hold their values until the next FINISH or reset; they SHALL NOT clear when start is accepted.
REQ-030 Latency, with start accepted at edge T:
  - match at entry j: WRITE at T+5+j, done at T+6+j.
  - cnt=0: done at T+5.
  - no match: done at T+5+cnt.
REQ-031 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-032 wr_en SHALL be high for exactly one cycle per lookup, and only in WRITE.

Reset
REQ-033 On nrst low, at any time and in any state, asynchronously: state=IDLE and address, wr_en, data_out, forAggregation, sink_idx, done, node_id, cnt, k, idx and match all 0.
REQ-034 A reset during WRITE SHALL drop wr_en immediately; no done pulse SHALL follow.

Verification
REQ-035 Bench, match case: ID=0x0001, count=3, entries {0x0005, 0x0001, 0x0007} -> writes 0x0003 to RESULT_ADDR, forAggregation=1, sink_idx=1, done at T+7.
REQ-036 Bench, no-match case: ID=0x0009, count=3, entries as above -> writes 0x0000, forAggregation=0, sink_idx=0, done at T+8; after a prior match, forAggregation falls only at FINISH.
REQ-037 Bench, zero count: count=0 -> no entry reads, writes 0x0000, done at T+5.
REQ-038 Bench, clamp: count=0x00FF with MAX_SINKS=8 and no match -> exactly 8 SCAN cycles, last read address SINK_BASE+8, done at T+13.
REQ-039 Bench, enable stall: en=0 for 3 cycles mid-SCAN -> address and state frozen, wr_en=0, done delayed by exactly 3 cycles, same result.
REQ-040 Bench, abort: nrst pulsed low during SCAN -> all outputs 0 asynchronously; start ignored mid-run; new start after reset completes normally.
